// File: rtl/alu_pkg.sv
// Shared definitions for the round-robin ALU scheduler: opcode set,
// result width, divide-by-zero code and response slot states.
package alu_pkg;

    localparam int RES_W = 8;
    localparam logic [RES_W-1:0] DIV0_CODE = 8'hFF;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_DIV  = 4'd3,
        OP_INC  = 4'd4,
        OP_DEC  = 4'd5,
        OP_AND  = 4'd6,
        OP_OR   = 4'd7,
        OP_NOT  = 4'd8,
        OP_NAND = 4'd9,
        OP_NOR  = 4'd10,
        OP_XOR  = 4'd11,
        OP_XNOR = 4'd12,
        OP_SHR  = 4'd13,
        OP_SHL  = 4'd14,
        OP_ASR  = 4'd15
    } alu_op_e;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 16-function ALU: 4-bit operands zero-extended to 8 bits,
// 8-bit result modulo 256, with a divide-by-zero flag.
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0]       a,
    input  logic [3:0]       b,
    input  logic [3:0]       sel,
    output logic [RES_W-1:0] result,
    output logic             div0
);

    logic [RES_W-1:0] a8;
    logic [RES_W-1:0] b8;

    assign a8 = {4'b0000, a};
    assign b8 = {4'b0000, b};

    // Inverting ops act on the extended operands, so the upper nibble reads as ones.
    always_comb begin
        result = '0;
        div0   = 1'b0;
        case (alu_op_e'(sel))
            OP_ADD:  result = a8 + b8;
            OP_SUB:  result = a8 - b8;
            OP_MUL:  result = a8 * b8;
            OP_DIV: begin
                if (b8 == '0) begin
                    result = DIV0_CODE;
                    div0   = 1'b1;
                end else begin
                    result = a8 / b8;
                end
            end
            OP_INC:  result = a8 + 8'd1;
            OP_DEC:  result = a8 - 8'd1;
            OP_AND:  result = a8 & b8;
            OP_OR:   result = a8 | b8;
            OP_NOT:  result = ~a8;
            OP_NAND: result = ~(a8 & b8);
            OP_NOR:  result = ~(a8 | b8);
            OP_XOR:  result = a8 ^ b8;
            OP_XNOR: result = ~(a8 ^ b8);
            OP_SHR:  result = a8 >> 1;
            OP_SHL:  result = a8 << 1;
            OP_ASR:  result = a8 >> 1;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one ALU core between N_REQ requesters,
// with a single registered response slot and a consumed-response counter.
module alu_rr_scheduler
    import alu_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [4*N_REQ-1:0]   req_a,
    input  logic [4*N_REQ-1:0]   req_b,
    input  logic [4*N_REQ-1:0]   req_sel,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [RES_W-1:0]     rsp_result,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err,
    output logic [15:0]          ops_done
);

    slot_state_e      state;
    slot_state_e      state_nxt;
    logic [ID_W-1:0]  last_grant;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_any;
    logic             slot_free;
    logic             accept;
    int unsigned      rr_idx;
    logic [3:0]       op_a;
    logic [3:0]       op_b;
    logic [3:0]       op_sel;
    logic [RES_W-1:0] alu_res;
    logic             alu_div0;

    assign rsp_valid = (state == SLOT_FULL);
    assign slot_free = !rsp_valid || rsp_ready;

    // First valid requester scanning upward from the one after last_grant.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        rr_idx  = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            rr_idx = (32'(last_grant) + k) % N_REQ;
            if (!gnt_any && req_valid[rr_idx]) begin
                gnt_any = 1'b1;
                gnt_id  = ID_W'(rr_idx);
            end
        end
    end

    assign accept = !rst && slot_free && gnt_any;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    assign op_a   = req_a[4*gnt_id +: 4];
    assign op_b   = req_b[4*gnt_id +: 4];
    assign op_sel = req_sel[4*gnt_id +: 4];

    alu_core u_alu (
        .a      (op_a),
        .b      (op_b),
        .sel    (op_sel),
        .result (alu_res),
        .div0   (alu_div0)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            SLOT_EMPTY: if (accept) state_nxt = SLOT_FULL;
            SLOT_FULL:  if (rsp_ready && !accept) state_nxt = SLOT_EMPTY;
            default:    state_nxt = SLOT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_result <= '0;
            rsp_id     <= '0;
            rsp_err    <= 1'b0;
            last_grant <= ID_W'(N_REQ - 1);
            ops_done   <= '0;
        end else begin
            if (accept) begin
                rsp_result <= alu_res;
                rsp_id     <= gnt_id;
                rsp_err    <= alu_div0;
                last_grant <= gnt_id;
            end
            if (rsp_valid && rsp_ready) begin
                ops_done <= ops_done + 16'd1;
            end
        end
    end

endmodule
